// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM, in-order request FIFO, wait-state
// sequencer and loader write port serving the fetch word-request interface.
module imem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WAIT   = 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              ins_req,
    input  logic [29:0]       addr,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic              ins_res,
    output logic [31:0]       data,
    output logic              stall,
    output logic              drop_err
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned WCNT_W    = 4;
    localparam int unsigned RAM_WORDS = 1 << ADDR_W;

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } state_t;

    logic [31:0]       mem  [RAM_WORDS];
    logic [ADDR_W-1:0] fifo [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              read_fire;

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;

    // Upper address bits alias onto the RAM and are intentionally ignored.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[29:ADDR_W];

    // FIFO status and next occupancy; flush discards everything including this edge's request.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        push       = ins_req && !full && !flush;
        count_next = count + CNT_W'(push) - CNT_W'(read_fire);
        if (flush) begin
            count_next = '0;
        end
    end

    // Sequencer next state: wait countdown, read edge, loader-write deferral, flush.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        read_fire  = 1'b0;
        if (flush) begin
            state_next = S_IDLE;
            wcnt_next  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (WAIT == 0) begin
                            read_fire = !prog_we;
                        end else begin
                            state_next = S_WAIT;
                            wcnt_next  = WCNT_W'(WAIT);
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt <= WCNT_W'(1)) begin
                        if (prog_we) begin
                            // Loader owns the RAM this edge; retry the read next edge.
                            wcnt_next = '0;
                        end else begin
                            read_fire = 1'b1;
                            if (count > CNT_W'(1)) begin
                                wcnt_next = WCNT_W'(WAIT);
                            end else begin
                                state_next = S_IDLE;
                                wcnt_next  = '0;
                            end
                        end
                    end else begin
                        wcnt_next = wcnt - WCNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    wcnt_next  = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (read_fire) begin
                    head <= head + PTR_W'(1);
                end
            end
        end
    end

    // Storage arrays are not reset; RAM contents survive reset.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            fifo[tail] <= addr[ADDR_W-1:0];
        end
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Registered response, stall decode and sticky overflow flag.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ins_res  <= 1'b0;
            data     <= '0;
            stall    <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            ins_res  <= read_fire;
            if (read_fire) begin
                data <= mem[fifo[head]];
            end
            stall    <= (count_next >= CNT_W'(DEPTH - 1));
            drop_err <= drop_err || (ins_req && full && !flush);
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder; four instances differing only in WAIT share all inputs.
module tb_imem_responder;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        ins_req = 1'b0;
    logic [29:0] addr    = '0;
    logic        flush   = 1'b0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;

    logic        res  [4];
    logic [31:0] dat  [4];
    logic        stl  [4];
    logic        derr [4];

    int checks   = 0;
    int failures = 0;

    // Instance index: 0 -> WAIT=0, 1 -> WAIT=1, 2 -> WAIT=3, 3 -> WAIT=15
    imem_responder #(.ADDR_W(10), .DEPTH(4), .WAIT(0)) u_w0 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins_req(ins_req), .addr(addr), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ins_res(res[0]), .data(dat[0]), .stall(stl[0]), .drop_err(derr[0]));
    imem_responder #(.ADDR_W(10), .DEPTH(4), .WAIT(1)) u_w1 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins_req(ins_req), .addr(addr), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ins_res(res[1]), .data(dat[1]), .stall(stl[1]), .drop_err(derr[1]));
    imem_responder #(.ADDR_W(10), .DEPTH(4), .WAIT(3)) u_w3 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins_req(ins_req), .addr(addr), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ins_res(res[2]), .data(dat[2]), .stall(stl[2]), .drop_err(derr[2]));
    imem_responder #(.ADDR_W(10), .DEPTH(4), .WAIT(15)) u_w15 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins_req(ins_req), .addr(addr), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ins_res(res[3]), .data(dat[3]), .stall(stl[3]), .drop_err(derr[3]));

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic ram_write(input logic [9:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic reset_pulse();
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
    endtask

    // Called right after the push edge: response expected exactly lat edges later.
    task automatic expect_resp(input int d, input int lat, input logic [31:0] exp, input string tag);
        for (int j = 1; j <= lat; j++) begin
            tick();
            if (j < lat) begin
                chk({tag, "_quiet"}, 32'(res[d]), 32'd0);
            end else begin
                chk({tag, "_res"}, 32'(res[d]), 32'd1);
                chk({tag, "_data"}, dat[d], exp);
            end
        end
        tick();
        chk({tag, "_pulse_end"}, 32'(res[d]), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_q [$];

        // 1: reset state and single read at WAIT=1
        ram_write(10'd5, 32'hA1B2_C3D4);
        chk("rst_ins_res", 32'(res[1]), 32'd0);
        chk("rst_data", dat[1], 32'd0);
        chk("rst_stall", 32'(stl[1]), 32'd0);
        chk("rst_drop_err", 32'(derr[1]), 32'd0);
        cpu_rst = 1'b0;
        tick();
        ins_req = 1'b1;
        addr    = 30'd5;
        tick();
        ins_req = 1'b0;
        chk("t1_push_quiet", 32'(res[1]), 32'd0);
        expect_resp(1, 2, 32'hA1B2_C3D4, "t1");
        chk("t1_drop_err", 32'(derr[1]), 32'd0);

        // 2: back-to-back at WAIT=0
        reset_pulse();
        for (int i = 0; i < 8; i++) ram_write(10'(i), 32'(i));
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                ins_req = 1'b1;
                addr    = 30'(k);
            end else begin
                ins_req = 1'b0;
            end
            tick();
            if (k > 0) begin
                chk("t2_res", 32'(res[0]), 32'd1);
                chk("t2_data", dat[0], 32'(k - 1));
            end
            chk("t2_stall", 32'(stl[0]), 32'd0);
        end
        tick();
        chk("t2_res_end", 32'(res[0]), 32'd0);

        // 3: stall and overflow at WAIT=15
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            ins_req = 1'b1;
            addr    = 30'(k);
            tick();
            if (k == 1) chk("t3_stall_2", 32'(stl[3]), 32'd0);
            if (k == 2) chk("t3_stall_3", 32'(stl[3]), 32'd1);
            if (k == 3) chk("t3_no_drop", 32'(derr[3]), 32'd0);
            if (k == 4) chk("t3_drop", 32'(derr[3]), 32'd1);
        end
        ins_req = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
        n = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (res[3] === 1'b1) begin
                n++;
                if (exp_q.size() > 0) chk("t3_data", dat[3], exp_q.pop_front());
            end
        end
        chk("t3_resp_count", 32'(n), 32'd4);
        chk("t3_drop_sticky", 32'(derr[3]), 32'd1);
        chk("t3_stall_drained", 32'(stl[3]), 32'd0);

        // 4: loader write collides with the read edge at WAIT=0
        reset_pulse();
        ram_write(10'd9, 32'd1);
        ins_req = 1'b1;
        addr    = 30'd9;
        tick();
        ins_req   = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 10'd9;
        prog_data = 32'd2;
        tick();
        prog_we = 1'b0;
        chk("t4_deferred", 32'(res[0]), 32'd0);
        tick();
        chk("t4_res", 32'(res[0]), 32'd1);
        chk("t4_data", dat[0], 32'd2);

        // 5: flush mid-wait at WAIT=3
        reset_pulse();
        for (int k = 1; k <= 3; k++) begin
            ins_req = 1'b1;
            addr    = 30'(k);
            tick();
        end
        ins_req = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (res[2] === 1'b1) n++;
        end
        chk("t5_no_res_after_flush", 32'(n), 32'd0);
        chk("t5_stall", 32'(stl[2]), 32'd0);
        ins_req = 1'b1;
        addr    = 30'd6;
        tick();
        ins_req = 1'b0;
        expect_resp(2, 4, 32'd6, "t5");

        // 6: async reset mid-wait, then address aliasing
        for (int k = 0; k < 3; k++) begin
            ins_req = 1'b1;
            addr    = 30'(k);
            tick();
        end
        ins_req = 1'b0;
        chk("t6_stall_before", 32'(stl[2]), 32'd1);
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("t6_async_stall", 32'(stl[2]), 32'd0);
        chk("t6_async_res", 32'(res[2]), 32'd0);
        tick();
        cpu_rst = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (res[2] === 1'b1) n++;
        end
        chk("t6_no_res_after_rst", 32'(n), 32'd0);
        ram_write(10'd5, 32'hCAFE_0005);
        ins_req = 1'b1;
        addr    = 30'h405;
        tick();
        ins_req = 1'b0;
        expect_resp(2, 4, 32'hCAFE_0005, "t6_alias");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
